button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, default 6, number of front-panel buttons handled.
REQ-002 Parameter DB_TICKS, default 200, consecutive stable ticks required to accept a level change (20 ms at 100 us tick).
REQ-003 Parameter RPT_DELAY, default 5000, held ticks before auto-repeat starts (500 ms).
REQ-004 Parameter RPT_PERIOD, default 1000, ticks between auto-repeat pulses (100 ms).
REQ-005 Parameter RPT_MASK, default 6'b111100, per-button auto-repeat enable: bits 5:2 are the plus/minus buttons, bits 1:0 are mode and load-defaults.
REQ-006 Port clk_2M5, input, 1, the block's single clock (2.5 MHz system clock).
REQ-007 Port reset_n, input, 1, asynchronous active-low reset.
REQ-008 Port tick, input, 1, single-cycle strobe every 100 us, synchronous to clk_2M5.
REQ-009 Port btn_n, input, N_BTN, raw buttons, push-to-ground, asynchronous to clk_2M5.
REQ-010 Port pressed, output, N_BTN, debounced level, 1 = held.
REQ-011 Port press_pulse, output, N_BTN, one clk_2M5 cycle high per accepted press or repeat.
REQ-012 Port any_pressed, output, 1, OR of pressed.

Function
REQ-013 Each btn_n bit shall pass through a 2-flop synchroniser and be inverted, giving raw_s (1 = pushed).
REQ-014 Debounce counters and FSMs shall advance only on cycles where tick=1; on all other cycles they shall hold.
REQ-015 Each channel shall implement the FSM IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE.
REQ-016 IDLE: on a tick with raw_s=1, go to DB_PRESS with cnt=1.
REQ-017 DB_PRESS: on a tick with raw_s=1, increment cnt; when cnt reaches DB_TICKS, go to HELD, set pressed=1, assert press_pulse for one cycle, clear cnt. On a tick with raw_s=0, return to IDLE with cnt=0.
REQ-018 HELD: count ticks while raw_s=1; if RPT_MASK bit=1 and cnt reaches RPT_DELAY, go to REPEAT, pulse press_pulse, clear cnt. On a tick with raw_s=0, go to DB_RELEASE with cnt=1.
REQ-019 REPEAT: count ticks; when cnt reaches RPT_PERIOD, pulse press_pulse and clear cnt, staying in REPEAT. On a tick with raw_s=0, go to DB_RELEASE with cnt=1.
REQ-020 DB_RELEASE: on a tick with raw_s=0, increment cnt; when cnt reaches DB_TICKS, go to IDLE with pressed=0. On a tick with raw_s=1, return to HELD with cnt=0, emit no pulse, and restart the repeat delay.
REQ-021 With RPT_MASK bit=0, HELD shall saturate cnt and never pulse again until release.
REQ-022 press_pulse shall be registered and occur in the cycle after the qualifying tick (latency 1 clk from tick, 2 clk plus synchroniser from the input).
REQ-023 Counters shall be ceil(log2(max(DB_TICKS,RPT_DELAY,RPT_PERIOD)+1)) bits wide, 13 bits at defaults, and shall never wrap.
REQ-024 Channels shall be fully independent; simultaneous presses on several buttons shall each produce pulses in the same cycle.
REQ-025 A tick arriving in the same cycle as an input edge shall sample the synchronised value, never the raw pin.

Reset
REQ-026 Assertion of reset_n=0 shall immediately force all FSMs to IDLE, all counters and synchronisers to 0, and pressed, press_pulse and any_pressed to 0, including mid-debounce or mid-repeat.
REQ-027 After reset release, a button already held shall be treated as a new press and produce exactly one press_pulse after DB_TICKS ticks.

Structure
REQ-028 A shared package shall hold the FSM state encoding, the default tick constants, and the button index constants BTN_MODE=0, BTN_LOAD=1, BTN_TL=2, BTN_TR=3, BTN_BL=4, BTN_BR=5.
REQ-029 The logic for one button shall be one sub-module, button_channel, instantiated N_BTN times in a generate loop; synchronisers and any_pressed shall sit in the top.
REQ-030 press_pulse[BTN_MODE] shall drive the mode state machine clock enable, and press_pulse[5:2] shall drive the POP timer plus/minus inputs.

Verification (DB_TICKS=4, RPT_DELAY=10, RPT_PERIOD=3, tick every 4 clk)
REQ-031 Clean press: btn_n[2] low for 30 ticks, then high -> pressed[2] high after 4 ticks; press_pulse[2] at tick 4, then ticks 14, 17, 20, 23, 26, 29; pressed low 4 ticks after release.
REQ-032 Bounce: btn_n[3] toggles every tick for 10 ticks, then stays low -> no pulse during toggling; exactly one pulse 4 ticks after it settles.
REQ-033 No-repeat button: btn_n[0] held for 40 ticks -> exactly one press_pulse[0].
REQ-034 Release glitch: btn_n[4] held in REPEAT, released for 2 ticks, then re-pressed -> pressed stays 1, no pulse at re-press, next pulse 10 ticks later.
REQ-035 Reset mid-hold: reset_n pulsed low while btn_n[5] is held in REPEAT -> all outputs 0 within the reset; after release, one pulse 4 ticks later.
REQ-036 Simultaneous press: btn_n[5:2] all low on the same cycle -> press_pulse[5:2] all assert in the same cycle, and any_pressed=1.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: shared state encoding, default timing constants and button indices
package button_conditioner_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DB_PRESS,
    ST_HELD,
    ST_REPEAT,
    ST_DB_RELEASE
  } btn_state_e;
  localparam int DEF_DB_TICKS   = 200;
  localparam int DEF_RPT_DELAY  = 5000;
  localparam int DEF_RPT_PERIOD = 1000;
  localparam int BTN_MODE = 0;
  localparam int BTN_LOAD = 1;
  localparam int BTN_TL   = 2;
  localparam int BTN_TR   = 3;
  localparam int BTN_BL   = 4;
  localparam int BTN_BR   = 5;
  // Counter width that holds the largest tick constant without wrapping
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/button_channel.sv
// button_channel: tick-paced debounce and auto-repeat FSM for one synchronised button
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int DB_TICKS   = DEF_DB_TICKS,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD,
  parameter bit RPT_EN     = 1'b1,
  parameter int CW         = cnt_width(DB_TICKS, RPT_DELAY, RPT_PERIOD)
) (
  input  logic clk_2M5,
  input  logic reset_n,
  input  logic tick,
  input  logic raw_s,
  output logic pressed,
  output logic press_pulse
);
  localparam logic [CW-1:0] DB_C  = CW'(DB_TICKS);
  localparam logic [CW-1:0] DLY_C = CW'(RPT_DELAY);
  localparam logic [CW-1:0] PER_C = CW'(RPT_PERIOD);
  btn_state_e state_q;
  logic [CW-1:0] cnt_q, cnt_inc;
  logic pressed_q, pulse_q;
  assign cnt_inc     = cnt_q + CW'(1);
  assign pressed     = pressed_q;
  assign press_pulse = pulse_q;
  // Whole channel advances only on tick; the pulse register self-clears every other cycle
  always_ff @(posedge clk_2M5 or negedge reset_n)
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (tick)
        case (state_q)
          ST_IDLE:
            if (raw_s) begin
              state_q <= ST_DB_PRESS;
              cnt_q   <= CW'(1);
            end
          ST_DB_PRESS:
            if (!raw_s) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else if (cnt_inc >= DB_C) begin
              state_q   <= ST_HELD;
              pressed_q <= 1'b1;
              pulse_q   <= 1'b1;
              cnt_q     <= '0;
            end else cnt_q <= cnt_inc;
          ST_HELD:
            if (!raw_s) begin
              state_q <= ST_DB_RELEASE;
              cnt_q   <= CW'(1);
            end else if (!RPT_EN) cnt_q <= (cnt_q >= DLY_C) ? cnt_q : cnt_inc;
            else if (cnt_inc >= DLY_C) begin
              state_q <= ST_REPEAT;
              pulse_q <= 1'b1;
              cnt_q   <= '0;
            end else cnt_q <= cnt_inc;
          ST_REPEAT:
            if (!raw_s) begin
              state_q <= ST_DB_RELEASE;
              cnt_q   <= CW'(1);
            end else if (cnt_inc >= PER_C) begin
              pulse_q <= 1'b1;
              cnt_q   <= '0;
            end else cnt_q <= cnt_inc;
          ST_DB_RELEASE:
            if (raw_s) begin
              state_q <= ST_HELD;
              cnt_q   <= '0;
            end else if (cnt_inc >= DB_C) begin
              state_q   <= ST_IDLE;
              pressed_q <= 1'b0;
              cnt_q     <= '0;
            end else cnt_q <= cnt_inc;
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises front-panel buttons and debounces/auto-repeats each one
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int               N_BTN      = 6,
  parameter int               DB_TICKS   = DEF_DB_TICKS,
  parameter int               RPT_DELAY  = DEF_RPT_DELAY,
  parameter int               RPT_PERIOD = DEF_RPT_PERIOD,
  parameter logic [N_BTN-1:0] RPT_MASK   = 6'b111100
) (
  input  logic             clk_2M5,
  input  logic             reset_n,
  input  logic             tick,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_pulse,
  output logic             any_pressed
);
  localparam int CW = cnt_width(DB_TICKS, RPT_DELAY, RPT_PERIOD);
  logic [N_BTN-1:0] sync1_q, sync2_q;
  // Inversion happens ahead of the flops so a reset synchroniser reads as "not pushed"
  always_ff @(posedge clk_2M5 or negedge reset_n)
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~btn_n;
      sync2_q <= sync1_q;
    end
  genvar i;
  generate
    for (i = 0; i < N_BTN; i++) begin : g_ch
      button_channel #(
        .DB_TICKS  (DB_TICKS),
        .RPT_DELAY (RPT_DELAY),
        .RPT_PERIOD(RPT_PERIOD),
        .RPT_EN    (RPT_MASK[i]),
        .CW        (CW)
      ) u_ch (
        .clk_2M5    (clk_2M5),
        .reset_n    (reset_n),
        .tick       (tick),
        .raw_s      (sync2_q[i]),
        .pressed    (pressed[i]),
        .press_pulse(press_pulse[i])
      );
    end
  endgenerate
  assign any_pressed = |pressed;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios with hand-computed tick-by-tick expectations
module tb_button_conditioner;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b1;
  logic tick = 1'b0;
  logic [5:0] btn_n = 6'b111111;
  logic [5:0] pressed, press_pulse;
  logic any_pressed;
  int nvec = 0;
  int nerr = 0;

  button_conditioner #(
    .N_BTN(6), .DB_TICKS(4), .RPT_DELAY(10), .RPT_PERIOD(3), .RPT_MASK(6'b111100)
  ) dut (
    .clk_2M5(clk), .reset_n(reset_n), .tick(tick), .btn_n(btn_n),
    .pressed(pressed), .press_pulse(press_pulse), .any_pressed(any_pressed)
  );

  task automatic step();
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic test_reset();
    nvec++; if (pressed !== 6'b0) begin nerr++; $display("FAIL reset_pressed got %b exp %b", pressed, 6'b0); end
    nvec++; if (press_pulse !== 6'b0) begin nerr++; $display("FAIL reset_pulse got %b exp %b", press_pulse, 6'b0); end
    nvec++; if (any_pressed !== 1'b0) begin nerr++; $display("FAIL reset_any got %b exp 0", any_pressed); end
  endtask

  task automatic test_release(input logic [5:0] bits, input string name);
    logic [5:0] eh;
    btn_n = 6'b111111;
    for (int t = 1; t <= 5; t++) begin
      step();
      eh = (t < 4) ? bits : 6'b0;
      nvec++; if (press_pulse !== 6'b0) begin nerr++; $display("FAIL %s_rel_pulse t=%0d got %b exp %b", name, t, press_pulse, 6'b0); end
      nvec++; if (pressed !== eh) begin nerr++; $display("FAIL %s_rel_pressed t=%0d got %b exp %b", name, t, pressed, eh); end
    end
  endtask

  task automatic test_clean_press();
    logic [5:0] ep, eh;
    logic ea;
    btn_n[2] = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      step();
      ep = ((t == 4) || (t >= 14 && (t - 14) % 3 == 0)) ? 6'b000100 : 6'b0;
      eh = (t >= 4) ? 6'b000100 : 6'b0;
      ea = (t >= 4);
      nvec++; if (press_pulse !== ep) begin nerr++; $display("FAIL clean_pulse t=%0d got %b exp %b", t, press_pulse, ep); end
      nvec++; if (pressed !== eh) begin nerr++; $display("FAIL clean_pressed t=%0d got %b exp %b", t, pressed, eh); end
      nvec++; if (any_pressed !== ea) begin nerr++; $display("FAIL clean_any t=%0d got %b exp %b", t, any_pressed, ea); end
    end
    test_release(6'b000100, "clean");
  endtask

  task automatic test_bounce();
    logic [5:0] ep, eh;
    for (int t = 1; t <= 10; t++) begin
      btn_n[3] = (t % 2 == 1) ? 1'b0 : 1'b1;
      step();
      nvec++; if (press_pulse !== 6'b0) begin nerr++; $display("FAIL bounce_pulse t=%0d got %b exp %b", t, press_pulse, 6'b0); end
      nvec++; if (pressed !== 6'b0) begin nerr++; $display("FAIL bounce_pressed t=%0d got %b exp %b", t, pressed, 6'b0); end
    end
    btn_n[3] = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      step();
      ep = (t == 4) ? 6'b001000 : 6'b0;
      eh = (t >= 4) ? 6'b001000 : 6'b0;
      nvec++; if (press_pulse !== ep) begin nerr++; $display("FAIL settle_pulse t=%0d got %b exp %b", t, press_pulse, ep); end
      nvec++; if (pressed !== eh) begin nerr++; $display("FAIL settle_pressed t=%0d got %b exp %b", t, pressed, eh); end
    end
    test_release(6'b001000, "bounce");
  endtask

  task automatic test_no_repeat();
    logic [5:0] ep, eh;
    btn_n[0] = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      step();
      ep = (t == 4) ? 6'b000001 : 6'b0;
      eh = (t >= 4) ? 6'b000001 : 6'b0;
      nvec++; if (press_pulse !== ep) begin nerr++; $display("FAIL norpt_pulse t=%0d got %b exp %b", t, press_pulse, ep); end
      nvec++; if (pressed !== eh) begin nerr++; $display("FAIL norpt_pressed t=%0d got %b exp %b", t, pressed, eh); end
    end
    test_release(6'b000001, "norpt");
  endtask

  task automatic test_release_glitch();
    logic [5:0] ep, eh;
    btn_n[4] = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      step();
      ep = (t == 4 || t == 14) ? 6'b010000 : 6'b0;
      eh = (t >= 4) ? 6'b010000 : 6'b0;
      nvec++; if (press_pulse !== ep) begin nerr++; $display("FAIL glitch_pulse t=%0d got %b exp %b", t, press_pulse, ep); end
      nvec++; if (pressed !== eh) begin nerr++; $display("FAIL glitch_pressed t=%0d got %b exp %b", t, pressed, eh); end
    end
    btn_n[4] = 1'b1;
    for (int t = 1; t <= 2; t++) begin
      step();
      nvec++; if (press_pulse !== 6'b0) begin nerr++; $display("FAIL glitch_gap_pulse t=%0d got %b exp %b", t, press_pulse, 6'b0); end
      nvec++; if (pressed !== 6'b010000) begin nerr++; $display("FAIL glitch_gap_pressed t=%0d got %b exp %b", t, pressed, 6'b010000); end
    end
    btn_n[4] = 1'b0;
    for (int r = 0; r <= 12; r++) begin
      step();
      ep = (r == 10) ? 6'b010000 : 6'b0;
      nvec++; if (press_pulse !== ep) begin nerr++; $display("FAIL glitch_repress_pulse r=%0d got %b exp %b", r, press_pulse, ep); end
      nvec++; if (pressed !== 6'b010000) begin nerr++; $display("FAIL glitch_repress_pressed r=%0d got %b exp %b", r, pressed, 6'b010000); end
    end
    test_release(6'b010000, "glitch");
  endtask

  task automatic test_reset_mid_hold();
    logic [5:0] ep, eh;
    btn_n[5] = 1'b0;
    for (int t = 1; t <= 14; t++) begin
      step();
      ep = (t == 4 || t == 14) ? 6'b100000 : 6'b0;
      nvec++; if (press_pulse !== ep) begin nerr++; $display("FAIL rstmid_pulse t=%0d got %b exp %b", t, press_pulse, ep); end
    end
    reset_n = 1'b0;
    #1;
    nvec++; if (press_pulse !== 6'b0) begin nerr++; $display("FAIL rstmid_async_pulse got %b exp %b", press_pulse, 6'b0); end
    nvec++; if (pressed !== 6'b0) begin nerr++; $display("FAIL rstmid_async_pressed got %b exp %b", pressed, 6'b0); end
    nvec++; if (any_pressed !== 1'b0) begin nerr++; $display("FAIL rstmid_async_any got %b exp 0", any_pressed); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      step();
      ep = (t == 4) ? 6'b100000 : 6'b0;
      eh = (t >= 4) ? 6'b100000 : 6'b0;
      nvec++; if (press_pulse !== ep) begin nerr++; $display("FAIL rstmid_after_pulse t=%0d got %b exp %b", t, press_pulse, ep); end
      nvec++; if (pressed !== eh) begin nerr++; $display("FAIL rstmid_after_pressed t=%0d got %b exp %b", t, pressed, eh); end
    end
    test_release(6'b100000, "rstmid");
  endtask

  task automatic test_simultaneous();
    logic [5:0] ep, eh;
    logic ea;
    btn_n[5:2] = 4'b0000;
    for (int t = 1; t <= 6; t++) begin
      step();
      ep = (t == 4) ? 6'b111100 : 6'b0;
      eh = (t >= 4) ? 6'b111100 : 6'b0;
      ea = (t >= 4);
      nvec++; if (press_pulse !== ep) begin nerr++; $display("FAIL simul_pulse t=%0d got %b exp %b", t, press_pulse, ep); end
      nvec++; if (pressed !== eh) begin nerr++; $display("FAIL simul_pressed t=%0d got %b exp %b", t, pressed, eh); end
      nvec++; if (any_pressed !== ea) begin nerr++; $display("FAIL simul_any t=%0d got %b exp %b", t, any_pressed, ea); end
    end
    test_release(6'b111100, "simul");
    nvec++; if (any_pressed !== 1'b0) begin nerr++; $display("FAIL simul_any_end got %b exp 0", any_pressed); end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_clean_press();
    test_bounce();
    test_no_repeat();
    test_release_glitch();
    test_reset_mid_hold();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
